// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// instr_fetch_queue : circular {pc, instr} buffer between fetch and decode
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module instr_fetch_queue #(
  parameter int DEPTH       = 2,
  parameter int ADDR_WIDTH  = 64,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic                       i_instr_valid,
  input  logic [INSTR_WIDTH-1:0]     i_instr,
  input  logic [ADDR_WIDTH-1:0]      i_pc,
  output logic                       o_instr_ready,
  input  logic                       i_stall,
  input  logic                       i_flush,
  output logic                       o_valid,
  output logic [INSTR_WIDTH-1:0]     o_instr,
  output logic [ADDR_WIDTH-1:0]      o_pc,
  output logic [6:0]                 o_op,
  output logic [2:0]                 o_func3,
  output logic                       o_func7_5,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int                     c_PTR_W = $clog2(DEPTH);
  localparam int                     c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0]     c_FULL  = c_CNT_W'(DEPTH);
  localparam logic [INSTR_WIDTH-1:0] c_NOP   = INSTR_WIDTH'(32'h0000_0013);

  logic [INSTR_WIDTH-1:0] r_instr_mem [DEPTH];
  logic [ADDR_WIDTH-1:0]  r_pc_mem    [DEPTH];
  logic [c_PTR_W-1:0]     r_wr_ptr;
  logic [c_PTR_W-1:0]     r_rd_ptr;
  logic [c_CNT_W-1:0]     r_count;

  logic w_push;
  logic w_pop;
  logic w_ready;
  logic w_valid;

  // Ready looks only at registered occupancy and flush, keeping i_stall off this path.
  assign w_ready = (r_count != c_FULL) && !i_flush;
  assign w_valid = (r_count != '0);
  assign w_push  = i_instr_valid && w_ready;
  assign w_pop   = w_valid && !i_stall;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + c_CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - c_CNT_W'(1);
    end
  end

  // Storage is never reset; only pointers and occupancy define what is live.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_instr_mem[r_wr_ptr] <= i_instr;
      r_pc_mem[r_wr_ptr]    <= i_pc;
    end
  end

  assign o_instr_ready = w_ready;
  assign o_valid       = w_valid;
  assign o_count       = r_count;
  assign o_instr       = w_valid ? r_instr_mem[r_rd_ptr] : c_NOP;
  assign o_pc          = w_valid ? r_pc_mem[r_rd_ptr]    : '0;
  assign o_op          = o_instr[6:0];
  assign o_func3       = o_instr[14:12];
  assign o_func7_5     = o_instr[30];

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_instr_fetch_queue : directed + random check against a queue-based model
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module tb_instr_fetch_queue;

  localparam int c_DEPTH = 2;

  logic        clk = 1'b0;
  logic        i_rstn;
  logic        i_instr_valid;
  logic [31:0] i_instr;
  logic [63:0] i_pc;
  logic        i_stall;
  logic        i_flush;
  logic        o_instr_ready;
  logic        o_valid;
  logic [31:0] o_instr;
  logic [63:0] o_pc;
  logic [6:0]  o_op;
  logic [2:0]  o_func3;
  logic        o_func7_5;
  logic [1:0]  o_count;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
  } ent_t;
  ent_t q[$];

  always #5 clk = ~clk;

  instr_fetch_queue #(
    .DEPTH(c_DEPTH), .ADDR_WIDTH(64), .INSTR_WIDTH(32)
  ) u_dut (
    .i_clk(clk), .i_rstn(i_rstn), .i_instr_valid(i_instr_valid),
    .i_instr(i_instr), .i_pc(i_pc), .o_instr_ready(o_instr_ready),
    .i_stall(i_stall), .i_flush(i_flush), .o_valid(o_valid),
    .o_instr(o_instr), .o_pc(o_pc), .o_op(o_op), .o_func3(o_func3),
    .o_func7_5(o_func7_5), .o_count(o_count)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_head();
    logic [31:0] e_ins;
    logic [63:0] e_pc;
    e_ins = (q.size() != 0) ? q[0].ins : 32'h0000_0013;
    e_pc  = (q.size() != 0) ? q[0].pc  : 64'h0;
    check_val("valid", o_valid, q.size() != 0);
    check_val("count", o_count, q.size());
    check_val("instr", o_instr, e_ins);
    check_val("pc",    o_pc,    e_pc);
    check_val("op",    o_op,    e_ins[6:0]);
    check_val("func3", o_func3, e_ins[14:12]);
    check_val("f7_5",  o_func7_5, e_ins[30]);
  endtask

  // Applies one cycle of stimulus, checks ready before the edge and the head after it.
  task automatic step(input logic rstn, input logic v, input logic [63:0] pc,
                      input logic [31:0] ins, input logic st, input logic fl);
    logic e_ready;
    logic do_pop;
    i_rstn = rstn; i_instr_valid = v; i_pc = pc; i_instr = ins;
    i_stall = st; i_flush = fl;
    #1;
    e_ready = (q.size() != c_DEPTH) && !fl;
    check_val("ready", o_instr_ready, e_ready);
    @(posedge clk);
    if (!rstn || fl) begin
      q.delete();
    end else begin
      do_pop = (q.size() != 0) && !st;
      if (do_pop) void'(q.pop_front());
      if (v && e_ready) q.push_back('{pc: pc, ins: ins});
    end
    #1;
    check_head();
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    i_rstn = 1'b0; i_instr_valid = 1'b0; i_pc = '0; i_instr = '0;
    i_stall = 1'b0; i_flush = 1'b0;
    @(negedge clk);

    // Reset then idle
    step(1'b0, 1'b1, 64'h44, 32'h1234_5678, 1'b0, 1'b0);
    step(1'b0, 1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
    check_val("rst_instr", o_instr, 64'h13);
    check_val("rst_op", o_op, 64'h13);
    check_val("rst_ready", o_instr_ready, 64'h1);
    idle();

    // Streaming: one per cycle, head follows the last push
    step(1'b1, 1'b1, 64'h0, 32'h0000_0093, 1'b0, 1'b0);
    check_val("str0_valid", o_valid, 64'h1);
    step(1'b1, 1'b1, 64'h4, 32'h0010_0113, 1'b0, 1'b0);
    check_val("str1_pc", o_pc, 64'h4);
    step(1'b1, 1'b1, 64'h8, 32'h0020_0193, 1'b0, 1'b0);
    check_val("str2_pc", o_pc, 64'h8);
    check_val("str2_cnt", o_count, 64'h1);
    idle();

    // Stall and fill, then drain
    step(1'b1, 1'b1, 64'h100, 32'h1111_1113, 1'b1, 1'b0);
    step(1'b1, 1'b1, 64'h104, 32'h2222_2213, 1'b1, 1'b0);
    check_val("fill_cnt", o_count, 64'h2);
    check_val("fill_ready", o_instr_ready, 64'h0);
    step(1'b1, 1'b1, 64'h108, 32'h3333_3313, 1'b1, 1'b0);
    check_val("full_head", o_pc, 64'h100);
    step(1'b1, 1'b1, 64'h108, 32'h3333_3313, 1'b0, 1'b0);
    check_val("drain_head", o_pc, 64'h104);
    step(1'b1, 1'b1, 64'h108, 32'h3333_3313, 1'b0, 1'b0);
    check_val("late_push", o_pc, 64'h108);
    idle();

    // Simultaneous push/pop at count=1, wrapping pointers
    step(1'b1, 1'b1, 64'h200, 32'h0000_0013, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 1'b1, 64'h200 + 64'(4 * k), $urandom, 1'b0, 1'b0);
      check_val("pp_pc", o_pc, 64'h200 + 64'(4 * k));
    end
    idle();

    // Flush beats a concurrent push
    step(1'b1, 1'b1, 64'h300, 32'h0000_0013, 1'b1, 1'b0);
    step(1'b1, 1'b1, 64'h304, 32'h0000_0013, 1'b1, 1'b0);
    step(1'b1, 1'b1, 64'h400, 32'h0000_0513, 1'b0, 1'b1);
    check_val("fl_cnt", o_count, 64'h0);
    check_val("fl_instr", o_instr, 64'h13);
    step(1'b1, 1'b1, 64'h400, 32'h0000_0513, 1'b0, 1'b0);
    check_val("fl_push", o_pc, 64'h400);
    idle();

    // Field split on sra, then reset with an entry live
    step(1'b1, 1'b1, 64'h500, 32'h4000_D0B3, 1'b1, 1'b0);
    check_val("sra_op", o_op, 64'h33);
    check_val("sra_f3", o_func3, 64'h5);
    check_val("sra_f7", o_func7_5, 64'h1);
    step(1'b0, 1'b1, 64'h504, 32'h0000_0013, 1'b1, 1'b0);
    check_val("rst_mid_valid", o_valid, 64'h0);
    idle();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 49) != 0),
           ($urandom_range(0, 9) < 7),
           {32'h0, $urandom} & 64'hFFFF_FFFC,
           $urandom,
           ($urandom_range(0, 9) < 3),
           ($urandom_range(0, 15) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
